// File: rtl/pixel_frame_loader.sv
`default_nettype none
// ============================================================================
//  Module   : pixel_frame_loader
//  Purpose  : Accepts a valid/ready stream of 8-bit grayscale pixels,
//             thresholds each byte to one bit and assembles a NUM_PIXELS-bit
//             frame in a shadow register. A completed frame is copied into
//             the published pixel_data vector and announced with
//             frame_valid; the consumer releases it with frame_ack.
//  Ports    : clk, reset      - clock, synchronous active-high reset
//             in_valid/in_data/in_sof/in_ready - pixel byte stream
//             pixel_data      - published frame (bit k = pixel k)
//             frame_valid     - pixel_data holds an unconsumed frame
//             frame_ack       - consumer releases the published frame
//             frame_abort     - one-cycle pulse, partial frame restarted
//             pixel_count     - pixels accepted into the shadow frame
//  Revision : 1.0 - initial release
// ============================================================================
module pixel_frame_loader #(
  parameter int unsigned NUM_PIXELS = 784,
  parameter int unsigned THRESHOLD  = 128,
  parameter int unsigned CNT_W      = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  input  logic                  in_sof,
  output logic                  in_ready,
  output logic [NUM_PIXELS-1:0] pixel_data,
  output logic                  frame_valid,
  input  logic                  frame_ack,
  output logic                  frame_abort,
  output logic [CNT_W-1:0]      pixel_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] c_last_idx  = CNT_W'(NUM_PIXELS - 1);
  localparam logic [CNT_W-1:0] c_full_cnt  = CNT_W'(NUM_PIXELS);
  localparam logic [7:0]       c_threshold = 8'(THRESHOLD);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [NUM_PIXELS-1:0] r_shadow;
  logic [NUM_PIXELS-1:0] w_shadow_nxt;
  logic [NUM_PIXELS-1:0] r_pixel_data;
  logic                  r_frame_valid;
  logic                  w_valid_nxt;
  logic                  r_frame_abort;
  logic                  w_abort_nxt;
  logic [CNT_W-1:0]      r_count;
  logic [CNT_W-1:0]      w_count_nxt;
  logic [CNT_W-1:0]      w_idx;
  logic                  w_xfer;
  logic                  w_bit;
  logic                  w_wr;
  logic                  w_copy;
  logic                  w_out_free;

  assign in_ready    = (r_state != ST_HOLD);
  assign w_xfer      = in_valid & in_ready;
  assign w_bit       = (in_data >= c_threshold);
  // An ack arriving together with a completion frees the output buffer.
  assign w_out_free  = ~r_frame_valid | frame_ack;

  assign pixel_data  = r_pixel_data;
  assign frame_valid = r_frame_valid;
  assign frame_abort = r_frame_abort;
  assign pixel_count = r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_shadow      <= '0;
      r_pixel_data  <= '0;
      r_frame_valid <= 1'b0;
      r_frame_abort <= 1'b0;
      r_count       <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_shadow      <= w_shadow_nxt;
      r_frame_valid <= w_valid_nxt;
      r_frame_abort <= w_abort_nxt;
      r_count       <= w_count_nxt;
      // The copy takes the shadow including the bit written this cycle.
      if (w_copy) begin
        r_pixel_data <= w_shadow_nxt;
      end
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_count_nxt  = r_count;
    w_shadow_nxt = r_shadow;
    w_idx        = '0;
    w_wr         = 1'b0;
    w_copy       = 1'b0;
    w_abort_nxt  = 1'b0;

    case (r_state)
      ST_IDLE: begin
        // Bytes without SOF are accepted and dropped.
        if (w_xfer && in_sof) begin
          w_wr  = 1'b1;
          w_idx = '0;
        end
      end
      ST_FILL: begin
        if (w_xfer) begin
          w_wr = 1'b1;
          if (in_sof) begin
            // Restart: stale shadow bits get overwritten as the frame refills.
            w_idx       = '0;
            w_abort_nxt = 1'b1;
          end else begin
            w_idx = r_count;
          end
        end
      end
      ST_HOLD: begin
        // frame_valid is always set here, so an ack releases the old frame.
        if (frame_ack) begin
          w_copy      = 1'b1;
          w_count_nxt = '0;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    if (w_wr) begin
      w_shadow_nxt[w_idx] = w_bit;
      if (w_idx == c_last_idx) begin
        if (w_out_free) begin
          w_copy      = 1'b1;
          w_count_nxt = '0;
          w_state_nxt = ST_IDLE;
        end else begin
          w_count_nxt = c_full_cnt;
          w_state_nxt = ST_HOLD;
        end
      end else begin
        w_count_nxt = w_idx + 1'b1;
        w_state_nxt = ST_FILL;
      end
    end

    // A copy always leaves a fresh frame published, even if acked this cycle.
    if (w_copy) begin
      w_valid_nxt = 1'b1;
    end else if (frame_ack) begin
      w_valid_nxt = 1'b0;
    end else begin
      w_valid_nxt = r_frame_valid;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pixel_frame_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pixel_frame_loader
//  Purpose  : Self-checking bench for pixel_frame_loader. Expected frames are
//             built from the stimulus bytes and queued; a monitor pops them
//             whenever the loader publishes a new frame.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pixel_frame_loader;

  localparam int NP = 784;
  localparam int CW = 10;

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_sof;
  logic          in_ready;
  logic [NP-1:0] pixel_data;
  logic          frame_valid;
  logic          frame_ack;
  logic          frame_abort;
  logic [CW-1:0] pixel_count;

  int n_vec = 0;
  int n_err = 0;

  logic [NP-1:0] sb_q[$];
  logic          last_pre_fv;

  pixel_frame_loader #(
    .NUM_PIXELS(NP),
    .THRESHOLD (128),
    .CNT_W     (CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_sof     (in_sof),
    .in_ready   (in_ready),
    .pixel_data (pixel_data),
    .frame_valid(frame_valid),
    .frame_ack  (frame_ack),
    .frame_abort(frame_abort),
    .pixel_count(pixel_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [NP-1:0] obs, input logic [NP-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Publish monitor: a rising frame_valid or new data under frame_valid.
  logic [NP-1:0] mon_prev_data;
  logic          mon_prev_valid;
  always @(negedge clk) begin
    if (frame_valid === 1'b1 &&
        (mon_prev_valid !== 1'b1 || pixel_data !== mon_prev_data)) begin
      n_vec++;
      assert (sb_q.size() != 0) else begin
        n_err++;
        $error("FAIL publish_unexpected observed=%0h expected=no_publish", pixel_data);
      end
      if (sb_q.size() != 0) chk("publish", pixel_data, sb_q.pop_front());
    end
    mon_prev_valid <= frame_valid;
    mon_prev_data  <= pixel_data;
  end

  function automatic logic [7:0] pat_byte(input int pat, input int k);
    case (pat)
      0:       return (k % 2 != 0) ? 8'd200 : 8'd10;
      1:       return (k == 0) ? 8'd127 : (k == 1) ? 8'd128 : (k == 2) ? 8'd255 : 8'd0;
      2:       return (k % 3 == 0) ? 8'd255 : 8'd0;
      default: return 8'((k * 7) % 256);
    endcase
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic sof);
    in_valid = 1'b1;
    in_data  = d;
    in_sof   = sof;
    cycle();
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_data  = 8'd0;
  endtask

  task automatic send_frame(input int pat, input logic ack_last, output logic [NP-1:0] e);
    logic [7:0] b;
    e = '0;
    for (int k = 0; k < NP; k++) begin
      b    = pat_byte(pat, k);
      e[k] = (b >= 8'd128);
      if (k == NP - 1) begin
        chk("count_before_last", NP'(pixel_count), NP'(NP - 1));
        last_pre_fv = frame_valid;
        sb_q.push_back(e);
        frame_ack = ack_last;
      end
      send(b, (k == 0));
      frame_ack = 1'b0;
    end
  endtask

  task automatic ack_cycle();
    frame_ack = 1'b1;
    cycle();
    frame_ack = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_data"},  pixel_data, '0);
    chk({tag, "_valid"}, NP'(frame_valid), NP'(0));
    chk({tag, "_count"}, NP'(pixel_count), NP'(0));
    chk({tag, "_abort"}, NP'(frame_abort), NP'(0));
    chk({tag, "_ready"}, NP'(in_ready), NP'(1));
  endtask

  initial begin
    logic [NP-1:0] f1, f2, f3, e1;
    in_valid  = 1'b0;
    in_data   = 8'd0;
    in_sof    = 1'b0;
    frame_ack = 1'b0;
    reset     = 1'b1;
    repeat (3) cycle();
    chk_reset_state("por");
    reset = 1'b0;

    // Alternating frame, latency and counter return.
    send_frame(0, 1'b0, f1);
    chk("alt_pre_valid", NP'(last_pre_fv), NP'(0));
    chk("alt_valid", NP'(frame_valid), NP'(1));
    chk("alt_data", pixel_data, {392{2'b10}});
    chk("alt_count", NP'(pixel_count), NP'(0));
    chk("alt_ready", NP'(in_ready), NP'(1));

    // Ack outside a copy clears valid and keeps data.
    ack_cycle();
    chk("ack_valid", NP'(frame_valid), NP'(0));
    chk("ack_data_kept", pixel_data, {392{2'b10}});

    // Bytes without SOF in IDLE are dropped.
    repeat (5) send(8'd200, 1'b0);
    chk("nosof_count", NP'(pixel_count), NP'(0));
    chk("nosof_valid", NP'(frame_valid), NP'(0));
    chk("nosof_ready", NP'(in_ready), NP'(1));

    // Threshold edges 127/128/255/0.
    send_frame(1, 1'b0, f1);
    chk("thr_low4", NP'(pixel_data[3:0]), NP'(4'b0110));
    chk("thr_frame", pixel_data, NP'(4'b0110));

    // Second frame without ack parks in HOLD.
    send_frame(2, 1'b0, f2);
    chk("hold_ready", NP'(in_ready), NP'(0));
    chk("hold_count", NP'(pixel_count), NP'(NP));
    chk("hold_data_old", pixel_data, f1);
    repeat (3) cycle();
    chk("hold_still", NP'(in_ready), NP'(0));
    ack_cycle();
    chk("release_data", pixel_data, f2);
    chk("release_valid", NP'(frame_valid), NP'(1));
    chk("release_ready", NP'(in_ready), NP'(1));
    chk("release_count", NP'(pixel_count), NP'(0));

    // Ack together with the last byte: copy wins, no HOLD.
    send_frame(3, 1'b1, f3);
    chk("ackl_pre_valid", NP'(last_pre_fv), NP'(1));
    chk("ackl_valid", NP'(frame_valid), NP'(1));
    chk("ackl_data", pixel_data, f3);
    chk("ackl_ready", NP'(in_ready), NP'(1));
    chk("ackl_count", NP'(pixel_count), NP'(0));
    ack_cycle();
    chk("ackl_release", NP'(frame_valid), NP'(0));

    // Restart after 300 bytes.
    for (int k = 0; k < 300; k++) send(8'($urandom), (k == 0));
    chk("pre_abort_count", NP'(pixel_count), NP'(300));
    send(8'd255, 1'b1);
    chk("abort_pulse", NP'(frame_abort), NP'(1));
    chk("abort_count", NP'(pixel_count), NP'(1));
    e1 = NP'(1);
    for (int k = 1; k < NP; k++) begin
      if (k == NP - 1) sb_q.push_back(e1);
      send(8'd0, 1'b0);
      if (k == 1) chk("abort_end", NP'(frame_abort), NP'(0));
    end
    chk("abort_frame", pixel_data, NP'(1));
    chk("abort_valid", NP'(frame_valid), NP'(1));
    ack_cycle();

    // Reset mid-frame.
    for (int k = 0; k < 500; k++) send(pat_byte(0, k), (k == 0));
    chk("mid_count", NP'(pixel_count), NP'(500));
    reset = 1'b1;
    cycle();
    sb_q.delete();
    chk_reset_state("rst_mid");
    reset = 1'b0;

    // Reset while in HOLD.
    send_frame(2, 1'b0, f2);
    send_frame(3, 1'b0, f3);
    chk("hold2_ready", NP'(in_ready), NP'(0));
    chk("hold2_count", NP'(pixel_count), NP'(NP));
    reset = 1'b1;
    cycle();
    sb_q.delete();
    chk_reset_state("rst_hold");
    reset = 1'b0;

    // Fresh frame after reset.
    send_frame(1, 1'b0, f1);
    chk("fresh_data", pixel_data, NP'(4'b0110));
    chk("fresh_valid", NP'(frame_valid), NP'(1));
    cycle();

    n_vec++;
    assert (sb_q.size() == 0) else begin
      n_err++;
      $error("FAIL unpublished_frames observed=%0d expected=0", sb_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pixel_frame_loader.md
Name: pixel_frame_loader

Overview:
Upstream feeder for the image memory stage. Accepts a byte stream of 8-bit grayscale pixels (UART RX or host bridge, valid/ready), thresholds each byte to 1 bit and assembles a 784-bit frame. The frame is double-buffered: a shadow register fills while the published pixel_data vector stays stable. A completed frame is published with a valid/ack handshake to the inference controller, which reads it through the image memory.

Parameters:
NUM_PIXELS, 784, pixels per frame (28x28); also the width of pixel_data.
THRESHOLD, 128, a byte >= THRESHOLD gives pixel bit 1; otherwise 0.
CNT_W, 10, pixel index counter width; must satisfy 2^CNT_W > NUM_PIXELS.

Ports:
clk  input  1  system clock; all state on rising edge.
reset  input  1  synchronous, active-high reset.
in_valid  input  1  in_data/in_sof are valid this cycle.
in_data  input  8  grayscale pixel byte.
in_sof  input  1  qualifies in_data as pixel 0 of a new frame.
in_ready  output  1  loader accepts the byte this cycle; transfer = in_valid & in_ready.
pixel_data  output  NUM_PIXELS  published frame; bit k = pixel k (image memory address k).
frame_valid  output  1  pixel_data holds an unconsumed complete frame.
frame_ack  input  1  consumer releases the published frame; ignored when frame_valid=0.
frame_abort  output  1  one-cycle pulse: partial frame discarded by a new in_sof.
pixel_count  output  CNT_W  pixels accepted into the current shadow frame.

Behaviour:
- Reset (synchronous, highest priority, also mid-frame): state IDLE, pixel_data=0, shadow=0, frame_valid=0, frame_abort=0, pixel_count=0. After reset, in_ready=1.
- States: IDLE (waiting for SOF), FILL (collecting), HOLD (shadow complete, output buffer occupied).
- in_ready is combinational from state: 1 in IDLE and FILL, 0 in HOLD.
- bit = (in_data >= THRESHOLD), unsigned compare.
- IDLE:
  - Transfer with in_sof=0: byte accepted and dropped; no state change.
  - Transfer with in_sof=1: shadow[0]=bit, pixel_count=1, go to FILL.
  - Edge case NUM_PIXELS=1: completes immediately; apply the completion rule below.
- FILL, transfer with in_sof=0: shadow[pixel_count]=bit; pixel_count increments.
- FILL, transfer with in_sof=1: restart. shadow[0]=bit, pixel_count=1, frame_abort=1 next cycle. Stale shadow bits are overwritten as the frame refills.
- Completion: the transfer that writes index NUM_PIXELS-1.
  - If output is free (frame_valid=0, or frame_ack=1 in the same cycle): pixel_data is copied from the completed shadow, including the final bit. frame_valid=1 on the next edge, i.e. latency 1 cycle after the last accepted byte. pixel_count=0, state IDLE.
  - Otherwise: state HOLD, pixel_count stays NUM_PIXELS.
- HOLD: on frame_ack, copy shadow to pixel_data; frame_valid stays 1; pixel_count=0; state IDLE on the next edge.
- Publish/ack (outside a copy): frame_ack with frame_valid=1 clears frame_valid next cycle; pixel_data keeps its old value.
- pixel_data changes only on a copy edge, never mid-read.
- Simultaneous ack and copy: the copy wins; frame_valid remains 1 with new data.
- Counter never wraps; index NUM_PIXELS-1 always terminates the frame.

Test Plan:
- Reset then 784 bytes, SOF on first, byte k = (k%2)?8'd200:8'd10 -> pixel_data = {392{2'b10}}; frame_valid rises exactly 1 cycle after last transfer; pixel_count returns to 0.
- Threshold edges: bytes 127, 128, 255, 0 at pixels 0-3, rest 0 -> pixel_data[3:0]=4'b0110.
- Back-to-back frames with no ack: second frame completes -> state HOLD, in_ready=0, pixel_data still frame 1; assert frame_ack -> next cycle pixel_data=frame 2, frame_valid=1, in_ready=1.
- Ack in the same cycle as the last byte while frame_valid=1 -> frame_valid stays 1, pixel_data updates to the new frame, no HOLD entry.
- 300 bytes then in_sof with byte 255 -> frame_abort pulses 1 cycle, pixel_count=1. Then 783 bytes of 0 -> published frame has only bit0=1.
- Bytes without SOF in IDLE -> accepted, dropped, pixel_count stays 0.
- Reset asserted mid-frame (count 500) and in HOLD -> all outputs zero next cycle; a fresh frame loads correctly.
